// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter, cyc-locked grants, with a slave-ack watchdog.
// Master 0 wins the first tie after reset; ties then alternate against the previous owner.
module wb_rr_arbiter #(
   parameter int AWIDTH  = 32,
   parameter int DWIDTH  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   input  logic              m0_we_i,
   input  logic [AWIDTH-1:0] m0_adr_i,
   input  logic [DWIDTH-1:0] m0_dat_i,
   output logic [DWIDTH-1:0] m0_dat_o,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   input  logic              m1_we_i,
   input  logic [AWIDTH-1:0] m1_adr_i,
   input  logic [DWIDTH-1:0] m1_dat_i,
   output logic [DWIDTH-1:0] m1_dat_o,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [AWIDTH-1:0] s_adr_o,
   output logic [DWIDTH-1:0] s_dat_o,
   input  logic [DWIDTH-1:0] s_dat_i,
   input  logic              s_ack_i,
   output logic [1:0]        gnt_o
);

   localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

   state_t        state;
   logic          last_gnt;
   logic [CW-1:0] wd_cnt;
   logic          sel_stb;
   logic          fire;

   // Strobe of the current owner, taken from the inputs so the watchdog
   // does not loop back through the output mux.
   assign sel_stb = ((state == GNT0) && m0_stb_i) || ((state == GNT1) && m1_stb_i);
   assign fire    = (TIMEOUT != 0) && sel_stb && !s_ack_i && (wd_cnt == TO_VAL);

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn)
         wd_cnt <= '0;
      else if (!sel_stb || s_ack_i)
         wd_cnt <= '0;
      else if (wd_cnt != TO_VAL)
         wd_cnt <= wd_cnt + CW'(1);
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
         gnt_o    <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (m0_cyc_i && (!m1_cyc_i || last_gnt)) begin
                  state    <= GNT0;
                  last_gnt <= 1'b0;
                  gnt_o    <= 2'b01;
               end else if (m1_cyc_i) begin
                  state    <= GNT1;
                  last_gnt <= 1'b1;
                  gnt_o    <= 2'b10;
               end
            end
            GNT0: begin
               if (!m0_cyc_i) begin
                  state <= IDLE;
                  gnt_o <= 2'b00;
               end else if (fire) begin
                  state <= ABORT;
               end
            end
            GNT1: begin
               if (!m1_cyc_i) begin
                  state <= IDLE;
                  gnt_o <= 2'b00;
               end else if (fire) begin
                  state <= ABORT;
               end
            end
            ABORT: begin
               // Hold the grant until the aborted master gives up its cycle.
               if (!(gnt_o[0] ? m0_cyc_i : m1_cyc_i)) begin
                  state <= IDLE;
                  gnt_o <= 2'b00;
               end
            end
            default: begin
               state <= IDLE;
               gnt_o <= 2'b00;
            end
         endcase
      end
   end

   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
      case (state)
         GNT0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = fire;
         end
         GNT1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = fire;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Two-master round-robin Wishbone arbiter with a bus watchdog. It shares the single Wishbone slave port between the AHB-to-Wishbone bridge (master 0) and a second Wishbone master (master 1, e.g. DMA or debug). It grants whole bus cycles (cyc-locked), routes handshakes and data, and aborts any transfer whose slave fails to acknowledge within a programmable number of cycles.

## Interface
Parameters:
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- TIMEOUT, 255, max wait cycles for s_ack_i while s_stb_o=1; 0 disables watchdog

Ports:
- hclk  in  1  clock, all logic on rising edge
- hresetn  in  1  reset; one clock; reset is asynchronous and active-low
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle/strobe/write
- m0_adr_i  in  AWIDTH  master 0 address
- m0_dat_i  in  DWIDTH  master 0 write data
- m0_dat_o  out  DWIDTH  read data to master 0
- m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge / error
- m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_dat_o, m1_ack_o, m1_err_o: same as m0_* for master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_adr_o  out  AWIDTH  to slave
- s_dat_o  out  DWIDTH  write data to slave
- s_dat_i  in  DWIDTH  read data from slave
- s_ack_i  in  1  slave acknowledge
- gnt_o  out  2  one-hot current grant (bit0=m0, bit1=m1), 00 when none

## Operation
- FSM states: IDLE, GNT0, GNT1, ABORT; encoded state and last_gnt register.
- IDLE: if only mX_cyc_i=1 -> GNTX. If both are 1 -> grant the master not equal to last_gnt. No request -> stay.
- On entry to GNTX, last_gnt <= X.
- GNTX: s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o = master X inputs (combinational mux); mX_ack_o = s_ack_i; other master ack/err = 0. Held while mX_cyc_i=1 (bus lock, multiple strobes allowed). mX_cyc_i=0 -> IDLE.
- Watchdog: counter (width clog2(TIMEOUT+1)) clears in IDLE, on s_ack_i=1, or when s_stb_o=0. It increments each cycle s_stb_o=1 and s_ack_i=0. When it equals TIMEOUT with s_ack_i still 0: mX_err_o=1 for that cycle, next state ABORT.
- ABORT: s_cyc_o=s_stb_o=0, all acks/errs 0, gnt_o unchanged. Wait for mX_cyc_i=0, then IDLE.
- mX_dat_o = s_dat_i at all times; qualified only by mX_ack_o.
- s_* outputs are all zero in IDLE and ABORT (address/data/we included).
- s_ack_i arriving in IDLE/ABORT is ignored (no ack to any master).
- A master dropping cyc mid-strobe ends the grant next edge; no ack is forwarded after release.

## Timing
- Reset (async, hresetn=0): state=IDLE, last_gnt=1 (m0 wins first tie), counter=0. All outputs 0: s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m*_ack_o, m*_err_o, gnt_o. mX_dat_o follows s_dat_i.
- Reset mid-transfer: bus released immediately (asynchronously); no ack/err emitted.
- Arbitration latency: request sampled at edge N, s_cyc_o asserted after edge N, i.e. 1 cycle after mX_cyc_i rises.
- Ack path is combinational: zero added latency on data phase.
- Release: mX_cyc_i low at edge N -> IDLE. Earliest next grant is after edge N+1 (one dead cycle between ownerships, also for the same master).
- Timeout: stb held for TIMEOUT cycles with no ack; err asserted in cycle TIMEOUT+1 after stb rise (counter reaches TIMEOUT); s_cyc_o low next cycle.
- TIMEOUT=0: counter never fires; ABORT unreachable.

## Test plan
- Reset: hresetn=0 during active GNT0 strobe -> all s_* and acks 0 same cycle; after release, IDLE, gnt_o=00.
- Single master: m0 read at adr 0x100, slave acks with 0xDEADBEEF after 2 wait cycles -> s_cyc_o 1 cycle after m0_cyc_i, m0_ack_o with m0_dat_o=0xDEADBEEF, m1_ack_o=0.
- Tie and rotation: both cyc asserted from reset -> m0 granted first; m0 releases -> one idle cycle -> m1 granted; both request again -> m0 granted.
- Bus lock: m0 holds cyc over 3 strobes while m1 requests -> m1 waits; gnt_o=01 until m0_cyc_i drops, then 10.
- Timeout: TIMEOUT=4, m1 strobes, slave never acks -> m1_err_o=1 for exactly one cycle 5 cycles after strobe, s_cyc_o=0 next cycle; grant stays until m1_cyc_i falls, then m0 request serviced normally.
- Late ack: s_ack_i pulsed in ABORT/IDLE -> no mX_ack_o asserted.
